// File: rtl/fp_alu_pkg.sv
// fp_alu_pkg: shared single-precision word, field widths and result-FIFO entry type
package fp_alu_pkg;
    localparam int FP_WIDTH = 32;
    localparam int EXP_W    = 8;
    localparam int MAN_W    = 23;
    typedef logic [FP_WIDTH-1:0] fp_word_t;
    typedef struct packed {
        logic     exc;
        fp_word_t data;
    } fp_entry_t;
endpackage

// File: rtl/fp_sat_counter.sv
// fp_sat_counter: saturating event counter with synchronous clear
//   clk, rst_n : clock, async active-low reset
//   clr        : clear to 0 (an increment in the same cycle yields 1)
//   inc        : count one event
//   count      : current value, sticks at all-ones
module fp_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);
    logic [W-1:0] count_q, count_d;
    always_comb count_d = inc ? (clr ? W'(1) : (&count_q ? count_q : count_q + W'(1))) : (clr ? '0 : count_q);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    assign count = count_q;
endmodule

// File: rtl/fp_result_fifo.sv
// fp_result_fifo: show-ahead FIFO of FP results with exception flag tracking
//   upstream  : in_valid, in_ready, in_data, in_exc
//   consumer  : out_valid, out_ready, out_data, out_exc (zeroed while empty)
//   status    : level, exc_sticky, exc_clear
//   exc_count : saturating exception count, present only with FP_EXC_COUNT_EN
module fp_result_fifo
    import fp_alu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [FP_WIDTH-1:0]      in_data,
    input  logic                     in_exc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FP_WIDTH-1:0]      out_data,
    output logic                     out_exc,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     exc_sticky,
`ifdef FP_EXC_COUNT_EN
    output logic [CNT_W-1:0]         exc_count,
`endif
    input  logic                     exc_clear
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = DEPTH[AW:0];
    fp_entry_t mem_q [DEPTH];
    fp_entry_t head;
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0] level_q, level_d;
    logic in_ready_q, sticky_q, push, pop;
    assign push = in_valid & in_ready_q;
    assign pop = out_valid & out_ready;
    assign level_d = level_q + (AW+1)'(push) - (AW+1)'(pop);
    // ready is registered from next level so out_ready never reaches it combinationally
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            wr_q       <= '0;
            rd_q       <= '0;
            level_q    <= '0;
            in_ready_q <= 1'b0;
            sticky_q   <= 1'b0;
        end else begin
            wr_q       <= push ? wr_q + AW'(1) : wr_q;
            rd_q       <= pop ? rd_q + AW'(1) : rd_q;
            level_q    <= level_d;
            in_ready_q <= level_d != FULL;
            sticky_q   <= (push & in_exc) | (sticky_q & ~exc_clear);
        end
    always_ff @(posedge clk)
        if (push) mem_q[wr_q] <= '{exc: in_exc, data: in_data};
    assign head = mem_q[rd_q];
    assign in_ready = in_ready_q;
    assign out_valid = level_q != '0;
    assign out_data = out_valid ? head.data : '0;
    assign out_exc = out_valid & head.exc;
    assign level = level_q;
    assign exc_sticky = sticky_q;
`ifdef FP_EXC_COUNT_EN
    fp_sat_counter #(.W(CNT_W)) u_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .clr  (exc_clear),
        .inc  (push & in_exc),
        .count(exc_count)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = ^CNT_W;
`endif
endmodule
